// File: rtl/jtroadf_objbuf.sv
// Road Fighter sprite line-buffer drawer: fetches one 16-pixel row, writes opaque pixels
// into a double-buffered line, and reads the other bank out. Option: JTROADF_OBJBUF_PROM_EN.
//
// state  | meaning
// IDLE   | waiting for draw on a cen2 cycle
// FETCH0 | rom_cs high until rom_ok, first half word
// DRAW0  | 8 pixels from the first word
// FETCH1 | rom_cs high until rom_ok, second half word
// DRAW1  | 8 pixels from the second word, then IDLE

module jtroadf_objbuf #(
  parameter logic [7:0] HOFFSET = 8'd6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pxl_cen,
  input  logic        cen2,
  input  logic        LHBL,
  input  logic        hinit_x,
  input  logic [8:0]  hdump,
  input  logic        draw,
  output logic        busy,
  input  logic [8:0]  code,
  input  logic [7:0]  xpos,
  input  logic [3:0]  pal,
  input  logic        hflip,
  input  logic        vflip,
  input  logic [3:0]  ysub,
  input  logic [3:0]  prog_data,
  input  logic [7:0]  prog_addr,
  input  logic        prog_en,
  output logic        rom_cs,
  output logic [13:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        rom_ok,
  output logic [3:0]  pxl
);

  typedef enum logic [2:0] {IDLE, FETCH0, DRAW0, FETCH1, DRAW1} state_t;

  state_t      state, next_state;
  logic        wr_bank;
  logic [7:0]  xpos_l;
  logic [3:0]  pal_l;
  logic        hflip_l;
  logic [31:0] data;
  logic [2:0]  cnt;
  logic        swap;
  logic        drawing;
  logic [3:0]  nib;
  logic [3:0]  colour;
  logic [7:0]  wr_col;
  logic        wr_en;
  logic [7:0]  rd_addr;
  logic [3:0]  rd_data;
  logic        clr_en;
  logic [3:0]  buf0 [256];
  logic [3:0]  buf1 [256];
  logic        unused_hdump;

  assign unused_hdump = hdump[8];
  assign swap    = hinit_x & cen2;
  assign drawing = (state == DRAW0) || (state == DRAW1);
  assign nib     = hflip_l ? data[31:28] : data[3:0];
  // cnt counts down, so ~cnt is the pixel index inside the half
  assign wr_col  = xpos_l + {4'd0, (state == DRAW1), ~cnt};
  assign wr_en   = cen2 & ~swap & drawing & (colour != 4'd0);
  assign rd_addr = hdump[7:0] + HOFFSET;
  assign clr_en  = pxl_cen & LHBL;
  assign rd_data = wr_bank ? buf0[rd_addr] : buf1[rd_addr];

`ifdef JTROADF_OBJBUF_PROM_EN
  logic [3:0] prom [256];

  always_ff @(posedge clk) begin
    if (prog_en) prom[prog_addr] <= prog_data;
  end

  assign colour = prom[{pal_l, nib}];
`else
  logic unused_prog;

  assign unused_prog = &{1'b0, prog_data, prog_addr, prog_en, pal_l};
  assign colour = nib;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // a line swap wins over everything, including a same-edge draw
  always_comb begin
    next_state = state;
    if (swap) begin
      next_state = IDLE;
    end else if (cen2) begin
      case (state)
        IDLE:    if (draw)        next_state = FETCH0;
        FETCH0:  if (rom_ok)      next_state = DRAW0;
        DRAW0:   if (cnt == 3'd0) next_state = FETCH1;
        FETCH1:  if (rom_ok)      next_state = DRAW1;
        DRAW1:   if (cnt == 3'd0) next_state = IDLE;
        default:                  next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank  <= 1'b0;
      busy     <= 1'b0;
      rom_cs   <= 1'b0;
      rom_addr <= 14'd0;
      xpos_l   <= 8'd0;
      pal_l    <= 4'd0;
      hflip_l  <= 1'b0;
      data     <= 32'd0;
      cnt      <= 3'd0;
    end else if (swap) begin
      wr_bank <= ~wr_bank;
      busy    <= 1'b0;
      rom_cs  <= 1'b0;
    end else if (cen2) begin
      busy   <= next_state != IDLE;
      rom_cs <= (next_state == FETCH0) || (next_state == FETCH1);
      case (state)
        IDLE: begin
          if (draw) begin
            xpos_l   <= xpos;
            pal_l    <= pal;
            hflip_l  <= hflip;
            rom_addr <= {code, ysub ^ {4{vflip}}, hflip};
          end
        end
        FETCH0, FETCH1: begin
          if (rom_ok) begin
            data <= rom_data;
            cnt  <= 3'd7;
          end
        end
        DRAW0, DRAW1: begin
          data <= hflip_l ? {data[27:0], 4'd0} : {4'd0, data[31:4]};
          cnt  <= cnt - 3'd1;
          if (state == DRAW0 && cnt == 3'd0) rom_addr[0] <= ~rom_addr[0];
        end
        default: ;
      endcase
    end
  end

  // each bank is either the draw target or the read/clear target, never both
  always_ff @(posedge clk) begin
    if (!wr_bank) begin
      if (wr_en) buf0[wr_col] <= colour;
    end else if (clr_en) begin
      buf0[rd_addr] <= 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_bank) begin
      if (wr_en) buf1[wr_col] <= colour;
    end else if (clr_en) begin
      buf1[rd_addr] <= 4'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          pxl <= 4'd0;
    else if (pxl_cen) pxl <= LHBL ? rd_data : 4'd0;
  end

endmodule

// File: tb/tb_jtroadf_objbuf.sv
// Directed bench for jtroadf_objbuf: draws known sprite rows, swaps banks and reads the
// line back, comparing against hand-computed pixels and handshake timing.

module tb_jtroadf_objbuf;

  logic        clk = 1'b0;
  logic        rst;
  logic        pxl_cen;
  logic        cen2 = 1'b0;
  logic        LHBL;
  logic        hinit_x;
  logic [8:0]  hdump;
  logic        draw;
  logic        busy;
  logic [8:0]  code;
  logic [7:0]  xpos;
  logic [3:0]  pal;
  logic        hflip;
  logic        vflip;
  logic [3:0]  ysub;
  logic [3:0]  prog_data;
  logic [7:0]  prog_addr;
  logic        prog_en;
  logic        rom_cs;
  logic [13:0] rom_addr;
  logic [31:0] rom_data;
  logic        rom_ok;
  logic [3:0]  pxl;

  logic [31:0] w0, w1;
  logic [3:0]  exp_line [256];
  int          total = 0;
  int          bad = 0;

  assign rom_data = rom_addr[0] ? w1 : w0;

  jtroadf_objbuf #(.HOFFSET(8'd6)) dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .cen2(cen2), .LHBL(LHBL),
    .hinit_x(hinit_x), .hdump(hdump), .draw(draw), .busy(busy), .code(code),
    .xpos(xpos), .pal(pal), .hflip(hflip), .vflip(vflip), .ysub(ysub),
    .prog_data(prog_data), .prog_addr(prog_addr), .prog_en(prog_en),
    .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok),
    .pxl(pxl)
  );

  always #5 clk = ~clk;
  always @(negedge clk) cen2 = ~cen2;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task read_px(input logic [7:0] col, input logic lhbl, output logic [3:0] v);
    logic [7:0] h;
    h = col - 8'd6;
    hdump = {1'b0, h};
    LHBL = lhbl;
    pxl_cen = 1'b1;
    @(posedge clk);
    #1;
    pxl_cen = 1'b0;
    LHBL = 1'b0;
    v = pxl;
  endtask

  task check_range(input logic [7:0] start, input int len);
    logic [7:0] col;
    logic [3:0] v;
    for (int i = 0; i < len; i++) begin
      col = start + 8'(i);
      read_px(col, 1'b1, v);
      check($sformatf("px_%02h", col), 32'(v), 32'(exp_line[col]));
    end
  endtask

  task clear_line;
    logic [3:0] v;
    for (int i = 0; i < 256; i++) read_px(8'(i), 1'b1, v);
  endtask

  task clear_exp;
    for (int i = 0; i < 256; i++) exp_line[i] = 4'd0;
  endtask

  // leaves us just after an edge where cen2=0, so the next edge is a cen2 edge
  task pre_cen2;
    @(posedge clk);
    while (cen2) @(posedge clk);
    #1;
  endtask

  task wait_cen2(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      while (!cen2) @(posedge clk);
    end
    #1;
  endtask

  task pulse_hinit;
    pre_cen2;
    hinit_x = 1'b1;
    @(posedge clk);
    #1 hinit_x = 1'b0;
  endtask

  task start_draw(input logic [8:0] c, input logic [7:0] x, input logic [3:0] p,
                  input logic [3:0] ys, input logic hf, input logic vf);
    pre_cen2;
    code = c; xpos = x; pal = p; ysub = ys; hflip = hf; vflip = vf;
    draw = 1'b1;
    @(posedge clk);
    #1 draw = 1'b0;
  endtask

  // counts cen2 edges until busy falls; rom_ok held low for the first 'hold' edges
  task measure(input int hold, output int n, output logic [13:0] a0, output logic [13:0] a1);
    logic c, prev_cs;
    bit   done;
    a0 = rom_addr;
    a1 = '0;
    n = 0;
    prev_cs = rom_cs;
    rom_ok = (hold == 0);
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      c = cen2;
      #1;
      if (c) begin
        n++;
        if (n == hold) begin
          check("cs_held", 32'(rom_cs), 32'd1);
          rom_ok = 1'b1;
        end
      end
      if (rom_cs && !prev_cs) a1 = rom_addr;
      prev_cs = rom_cs;
      if (!busy) done = 1;
    end
    if (!done) check("busy_tmo", 32'(busy), 32'd0);
  endtask

  int          n;
  logic [13:0] a0, a1;
  logic [3:0]  v;

  initial begin
    rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b0; hinit_x = 1'b0; hdump = '0; draw = 1'b0;
    code = '0; xpos = '0; pal = '0; hflip = 1'b0; vflip = 1'b0; ysub = '0;
    prog_data = '0; prog_addr = '0; prog_en = 1'b0; rom_ok = 1'b1; w0 = '0; w1 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cs", 32'(rom_cs), 32'd0);
    check("rst_addr", 32'(rom_addr), 32'd0);
    check("rst_pxl", 32'(pxl), 32'd0);

    for (int i = 0; i < 256; i++) begin
      prog_addr = 8'(i);
      prog_data = 4'(i);
      prog_en = 1'b1;
      @(posedge clk);
      #1;
    end
    prog_en = 1'b0;

    // scrub both banks, ending with write bank 0
    clear_line;
    pulse_hinit;
    clear_line;
    pulse_hinit;

    w0 = 32'h87654321; w1 = 32'hFEDCBA98;
    start_draw(9'h005, 8'h40, 4'd0, 4'd3, 1'b0, 1'b0);
    measure(0, n, a0, a1);
    check("busy_len_a", 32'(n), 32'd18);
    check("addr0_a", 32'(a0), 32'h00A6);
    check("addr1_a", 32'(a1), 32'h00A7);

    w0 = 32'h00000000; w1 = 32'h33333333;
    start_draw(9'h005, 8'h44, 4'd2, 4'd3, 1'b0, 1'b0);
    measure(0, n, a0, a1);
    check("busy_len_b", 32'(n), 32'd18);

    pulse_hinit;
    clear_exp;
    for (int i = 0; i < 8; i++) exp_line[8'h40 + i] = 4'(1 + i);
    for (int i = 0; i < 4; i++) exp_line[8'h48 + i] = 4'(8 + i);
    for (int i = 0; i < 8; i++) exp_line[8'h4C + i] = 4'd3;
    check_range(8'h3F, 22);
    read_px(8'h40, 1'b1, v);
    check("cleared_40", 32'(v), 32'd0);

    w0 = 32'h87654321; w1 = 32'hFEDCBA98;
    start_draw(9'h005, 8'hF8, 4'd2, 4'd3, 1'b1, 1'b1);
    measure(0, n, a0, a1);
    check("busy_len_c", 32'(n), 32'd18);
    check("addr0_c", 32'(a0), 32'h00B9);
    check("addr1_c", 32'(a1), 32'h00B8);

    start_draw(9'h005, 8'h80, 4'd2, 4'd3, 1'b0, 1'b0);
    measure(10, n, a0, a1);
    check("busy_len_d", 32'(n), 32'd28);

    pulse_hinit;
    read_px(8'h80, 1'b0, v);
    check("lhbl_low", 32'(v), 32'd0);
    clear_exp;
    for (int i = 0; i < 8; i++) begin
      exp_line[8'hF8 + i] = 4'(15 - i);
      exp_line[i]         = 4'(8 - i);
      exp_line[8'h80 + i] = 4'(1 + i);
      exp_line[8'h88 + i] = 4'(8 + i);
    end
    check_range(8'hF7, 18);
    check_range(8'h80, 16);

    pre_cen2;
    code = 9'h005; xpos = 8'h20; draw = 1'b1; hinit_x = 1'b1;
    @(posedge clk);
    #1 draw = 1'b0; hinit_x = 1'b0;
    check("swap_wins", 32'(busy), 32'd0);
    wait_cen2(3);
    check("swap_wins_late", 32'(busy), 32'd0);
    check("swap_wins_cs", 32'(rom_cs), 32'd0);

    start_draw(9'h005, 8'h10, 4'd2, 4'd3, 1'b0, 1'b0);
    wait_cen2(10);
    check("busy_e", 32'(busy), 32'd1);
    draw = 1'b1;
    wait_cen2(1);
    draw = 1'b0;
    wait_cen2(1);
    hinit_x = 1'b1;
    wait_cen2(1);
    hinit_x = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cs", 32'(rom_cs), 32'd0);
    wait_cen2(2);
    check("no_redraw", 32'(busy), 32'd0);

    clear_exp;
    for (int i = 0; i < 8; i++) exp_line[8'h10 + i] = 4'(1 + i);
    check_range(8'h10, 8);
    clear_line;
    clear_exp;
    check_range(8'h10, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
